// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: ALU opcodes, arbiter FSM states, data width
// and the two-port winner selection used in IDLE.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_NOT  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_LNOT = 4'b0110;
    localparam logic [3:0] ALU_LAND = 4'b0111;
    localparam logic [3:0] ALU_SHR  = 4'b1000;
    localparam logic [3:0] ALU_SHL  = 4'b1001;
    localparam logic [3:0] ALU_EQ   = 4'b1010;
    localparam logic [3:0] ALU_GT   = 4'b1011;
    localparam logic [3:0] ALU_GE   = 4'b1100;
    localparam logic [3:0] ALU_LOR  = 4'b1101;
    localparam logic [3:0] ALU_XOR  = 4'b1110;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_EXEC = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_t;

    // Ties go to the port that did not win last (round-robin) or to port 0 (fixed).
    function automatic logic arb_pick(input logic v0, input logic v1,
                                      input logic last, input logic prio_fixed);
        if (v0 && v1) begin
            return prio_fixed ? 1'b0 : ~last;
        end
        return v1 && !v0;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Registered 16-bit ALU: result appears one clock after op/a/b, no reset, no handshake;
// the result register reloads every cycle, so stable inputs give a stable result.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] r_result;

    always_comb begin
        w_result = i_a;
        case (i_op)
            ALU_ADD:  w_result = i_a + i_b;
            ALU_SUB:  w_result = i_a - i_b;
            ALU_MUL:  w_result = i_a * i_b;
            ALU_NOT:  w_result = ~i_a;
            ALU_OR:   w_result = i_a | i_b;
            ALU_AND:  w_result = i_a & i_b;
            ALU_LNOT: w_result = {{(DATA_W-1){1'b0}}, !i_a};
            ALU_LAND: w_result = {{(DATA_W-1){1'b0}}, i_a && i_b};
            ALU_SHR:  w_result = i_a >> i_b;
            ALU_SHL:  w_result = i_a << i_b;
            ALU_EQ:   w_result = {{(DATA_W-1){1'b0}}, i_a == i_b};
            ALU_GT:   w_result = {{(DATA_W-1){1'b0}}, i_a > i_b};
            ALU_GE:   w_result = {{(DATA_W-1){1'b0}}, i_a >= i_b};
            ALU_LOR:  w_result = {{(DATA_W-1){1'b0}}, i_a || i_b};
            ALU_XOR:  w_result = i_a ^ i_b;
            default:  w_result = i_a;
        endcase
    end

    always_ff @(posedge clk) begin
        r_result <= w_result;
    end

    assign o_result = r_result;

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one registered ALU: accept -> result valid in 2 cycles, 3 cycles/op,
// one op in flight; the response holds until resp_ready. Optional resp zero flags under ALU_ARB_ZERO_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              busy,
    output logic              grant
`ifdef ALU_ARB_ZERO_EN
    ,
    output logic              resp0_zero,
    output logic              resp1_zero
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_grant;
    logic              r_owner;
    logic [3:0]        r_op_q;
    logic [DATA_W-1:0] r_a_q;
    logic [DATA_W-1:0] r_b_q;

    logic              w_any_vld;
    logic              w_winner;
    logic [DATA_W-1:0] w_alu_result;

    assign w_any_vld = req0_valid || req1_valid;
    assign w_winner  = arb_pick(req0_valid, req1_valid, r_last_grant, PRIO_MODE != 0);
    assign busy      = (r_state != ARB_IDLE);

    // Outside IDLE, grant reports the owner of the transaction in flight.
    always_comb begin
        w_state_nxt  = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        resp0_result = '0;
        resp1_result = '0;
        grant        = r_owner;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_vld) begin
                    w_state_nxt = ARB_EXEC;
                    if (!rst) begin
                        grant      = w_winner;
                        req0_ready = !w_winner;
                        req1_ready = w_winner;
                    end
                end
            end
            ARB_EXEC: w_state_nxt = ARB_RESP;
            ARB_RESP: begin
                if (r_owner) begin
                    resp1_valid  = 1'b1;
                    resp1_result = w_alu_result;
                    if (resp1_ready) w_state_nxt = ARB_IDLE;
                end else begin
                    resp0_valid  = 1'b1;
                    resp0_result = w_alu_result;
                    if (resp0_ready) w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op_q       <= '0;
            r_a_q        <= '0;
            r_b_q        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_any_vld) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_op_q       <= w_winner ? req1_op : req0_op;
                r_a_q        <= w_winner ? req1_a  : req0_a;
                r_b_q        <= w_winner ? req1_b  : req0_b;
            end
        end
    end

    // Operands stay latched through RESP so the ALU re-registers the same result under backpressure.
    alu_arbiter_alu u_alu (
        .clk      (clk),
        .i_op     (r_op_q),
        .i_a      (r_a_q),
        .i_b      (r_b_q),
        .o_result (w_alu_result)
    );

`ifdef ALU_ARB_ZERO_EN
    logic w_res_zero;
    assign w_res_zero = (w_alu_result == '0);
    assign resp0_zero = resp0_valid && w_res_zero;
    assign resp1_zero = resp1_valid && w_res_zero;
`endif

endmodule
